// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl: 640x480 @ 60 Hz VGA timing generator.
// Divides the system clock down to a pixel tick. Runs the horizontal and vertical pixel
// counters, and drives the registered sync, blanking and frame-start strobes.
//
// Ports
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   o_p_tick       one-clk pulse per pixel period
//   o_pixel_x      horizontal count, 0..H_TOTAL-1
//   o_pixel_y      vertical count, 0..V_TOTAL-1
//   o_video_on     high inside the visible area
//   o_hsync        horizontal sync, active-low
//   o_vsync        vertical sync, active-low
//   o_frame_start  one-clk pulse after the counters wrap to (0,0)
module vga_sync_ctrl #(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  output logic       o_p_tick,
  output logic [9:0] o_pixel_x,
  output logic [9:0] o_pixel_y,
  output logic       o_video_on,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_frame_start
);

  localparam int unsigned HTotal = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast    = DivW'(TICK_DIV - 1);
  localparam logic [9:0]      HLast      = 10'(HTotal - 1);
  localparam logic [9:0]      VLast      = 10'(VTotal - 1);
  localparam logic [9:0]      HDisp      = 10'(H_DISPLAY);
  localparam logic [9:0]      VDisp      = 10'(V_DISPLAY);
  localparam logic [9:0]      HSyncStart = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0]      HSyncEnd   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0]      VSyncStart = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0]      VSyncEnd   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic [DivW-1:0] r_div_cnt, w_div_next;
  logic [9:0]      r_h_cnt, w_h_next;
  logic [9:0]      r_v_cnt, w_v_next;
  logic            r_hsync, w_hsync_next;
  logic            r_vsync, w_vsync_next;
  logic            r_video_on, w_video_on_next;
  logic            r_frame_start, w_frame_start_next;
  logic            w_p_tick;
  logic            w_h_wrap;
  logic            w_v_wrap;

  assign w_p_tick = (r_div_cnt == DivLast);
  assign w_h_wrap = (r_h_cnt == HLast);
  assign w_v_wrap = (r_v_cnt == VLast);

  // Outputs are decoded from the next-state counters so they switch on the same edge as
  // the counters themselves, with no combinational decode on the output pins.
  always_comb begin
    w_div_next         = w_p_tick ? '0 : r_div_cnt + DivW'(1);
    w_h_next           = r_h_cnt;
    w_v_next           = r_v_cnt;
    w_frame_start_next = 1'b0;
    if (w_p_tick) begin
      w_h_next = w_h_wrap ? '0 : r_h_cnt + 10'd1;
      if (w_h_wrap) begin
        w_v_next           = w_v_wrap ? '0 : r_v_cnt + 10'd1;
        w_frame_start_next = w_v_wrap;
      end
    end
    w_hsync_next    = !((w_h_next >= HSyncStart) && (w_h_next <= HSyncEnd));
    w_vsync_next    = !((w_v_next >= VSyncStart) && (w_v_next <= VSyncEnd));
    w_video_on_next = (w_h_next < HDisp) && (w_v_next < VDisp);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div_cnt     <= '0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div_cnt     <= w_div_next;
      r_h_cnt       <= w_h_next;
      r_v_cnt       <= w_v_next;
      r_hsync       <= w_hsync_next;
      r_vsync       <= w_vsync_next;
      r_video_on    <= w_video_on_next;
      r_frame_start <= w_frame_start_next;
    end
  end

  assign o_p_tick      = w_p_tick;
  assign o_pixel_x     = r_h_cnt;
  assign o_pixel_y     = r_v_cnt;
  assign o_video_on    = r_video_on;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb_vga_sync_ctrl: directed bench for vga_sync_ctrl.
// u_a: default 640x480 timing, TICK_DIV=4 (reset, first line, async mid-line reset).
// u_b: default geometry with TICK_DIV=2 (line period and hsync width).
// u_c: shrunken 15x8 geometry with TICK_DIV=2 so that whole frames fit in a short run.
module tb_vga_sync_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  logic       a_pt, a_vid, a_hs, a_vs, a_fs;
  logic [9:0] a_px, a_py;
  logic       b_pt, b_vid, b_hs, b_vs, b_fs;
  logic [9:0] b_px, b_py;
  logic       c_pt, c_vid, c_hs, c_vs, c_fs;
  logic [9:0] c_px, c_py;

  vga_sync_ctrl u_a (
    .i_clk(clk), .i_reset_n(reset_n), .o_p_tick(a_pt), .o_pixel_x(a_px), .o_pixel_y(a_py),
    .o_video_on(a_vid), .o_hsync(a_hs), .o_vsync(a_vs), .o_frame_start(a_fs)
  );

  vga_sync_ctrl #(.TICK_DIV(2)) u_b (
    .i_clk(clk), .i_reset_n(reset_n), .o_p_tick(b_pt), .o_pixel_x(b_px), .o_pixel_y(b_py),
    .o_video_on(b_vid), .o_hsync(b_hs), .o_vsync(b_vs), .o_frame_start(b_fs)
  );

  // 15 pixels x 8 lines; hsync on x in [10,12], vsync on y in {5,6}, visible 8x4.
  vga_sync_ctrl #(
    .TICK_DIV(2), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_c (
    .i_clk(clk), .i_reset_n(reset_n), .o_p_tick(c_pt), .o_pixel_x(c_px), .o_pixel_y(c_py),
    .o_video_on(c_vid), .o_hsync(c_hs), .o_vsync(c_vs), .o_frame_start(c_fs)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then park on the following falling edge to sample.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_a(input string pfx);
    check({pfx, "_p_tick"},      int'(a_pt),  0);
    check({pfx, "_pixel_x"},     int'(a_px),  0);
    check({pfx, "_pixel_y"},     int'(a_py),  0);
    check({pfx, "_hsync"},       int'(a_hs),  1);
    check({pfx, "_vsync"},       int'(a_vs),  1);
    check({pfx, "_video_on"},    int'(a_vid), 0);
    check({pfx, "_frame_start"}, int'(a_fs),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // u_a line events
    int hs_fall_e = -1, hs_fall_px = -1, hs_rise_e = -1, hs_rise_px = -1, hs_low = 0;
    int vid_fall_e = -1, vid_fall_px = -1, wrap_e = -1, wrap_py = -1;
    // u_b line events
    int b_fall_e = -1, b_fall_px = -1, b_low = 0, b_wrap1 = -1, b_wrap2 = -1;
    // u_c frame events
    int fs_cnt = 0, fs1 = -1, fs2 = -1, fs_wide = 0, c_vid_f1 = 0, c_vid_f2 = 0;
    int c_vs_low = 0, c_vs_bad = 0, c_ywrap_e = -1;
    logic p_a_hs, p_a_vid, p_b_hs, p_c_fs;
    logic [9:0] p_a_px, p_b_px, p_c_py;
    int w;

    // Reset held for 12 clocks.
    step(12);
    check_reset_a("rst");
    check("rst_b_hsync", int'(b_hs), 1);
    check("rst_c_vsync", int'(c_vs), 1);

    p_a_hs = a_hs; p_a_vid = a_vid; p_a_px = a_px;
    p_b_hs = b_hs; p_b_px = b_px; p_c_fs = c_fs; p_c_py = c_py;
    reset_n = 1'b1;

    for (int e = 1; e <= 3200; e++) begin
      step(1);
      // First-edge sequencing after release: p_tick after edges 3 and 7, x=1 from edge 4.
      case (e)
        1: begin
          check("e1_video_on", int'(a_vid), 1);
          check("e1_pixel_x", int'(a_px), 0);
          check("e1_p_tick", int'(a_pt), 0);
        end
        3: check("e3_p_tick", int'(a_pt), 1);
        4: check("e4_p_tick", int'(a_pt), 0);
        5: check("e5_pixel_x", int'(a_px), 1);
        7: check("e7_p_tick", int'(a_pt), 1);
        9: check("e9_pixel_x", int'(a_px), 2);
        default: ;
      endcase

      if (p_a_hs && !a_hs && hs_fall_e < 0) begin hs_fall_e = e; hs_fall_px = int'(a_px); end
      if (!p_a_hs && a_hs && hs_rise_e < 0) begin hs_rise_e = e; hs_rise_px = int'(a_px); end
      if (!a_hs) hs_low++;
      if (p_a_vid && !a_vid && vid_fall_e < 0) begin vid_fall_e = e; vid_fall_px = int'(a_px); end
      if (p_a_px == 10'd799 && a_px == 10'd0 && wrap_e < 0) begin
        wrap_e = e; wrap_py = int'(a_py);
      end

      if (p_b_hs && !b_hs && b_fall_e < 0) begin b_fall_e = e; b_fall_px = int'(b_px); end
      if (!b_hs && e <= 1600) b_low++;
      if (p_b_px == 10'd799 && b_px == 10'd0) begin
        if (b_wrap1 < 0) b_wrap1 = e;
        else if (b_wrap2 < 0) b_wrap2 = e;
      end

      if (c_fs) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = e;
        else if (fs2 < 0) fs2 = e;
        if (p_c_fs) fs_wide++;
      end
      if (c_pt && c_vid && e <= 240) c_vid_f1++;
      if (c_pt && c_vid && e > 240 && e <= 480) c_vid_f2++;
      if (!c_vs && e <= 240) c_vs_low++;
      if (c_vs !== !(c_py == 10'd5 || c_py == 10'd6)) c_vs_bad++;
      if (p_c_py == 10'd7 && c_py == 10'd0 && c_ywrap_e < 0) c_ywrap_e = e;

      p_a_hs = a_hs; p_a_vid = a_vid; p_a_px = a_px;
      p_b_hs = b_hs; p_b_px = b_px; p_c_fs = c_fs; p_c_py = c_py;
    end

    // Default timing, first line.
    check("hs_fall_edge", hs_fall_e, 2624);
    check("hs_fall_px", hs_fall_px, 656);
    check("hs_rise_edge", hs_rise_e, 3008);
    check("hs_rise_px", hs_rise_px, 752);
    check("hs_low_clk", hs_low, 384);
    check("vid_fall_edge", vid_fall_e, 2560);
    check("vid_fall_px", vid_fall_px, 640);
    check("x_wrap_edge", wrap_e, 3200);
    check("x_wrap_py", wrap_py, 1);
    check("a_vsync_line1", int'(a_vs), 1);

    // TICK_DIV=2: halved clock counts, same pixel boundaries.
    check("b_hs_fall_edge", b_fall_e, 1312);
    check("b_hs_fall_px", b_fall_px, 656);
    check("b_hs_low_clk", b_low, 192);
    check("b_line_period", b_wrap2 - b_wrap1, 1600);

    // Small geometry: frame is 15*8*2 = 240 clk.
    check("c_fs_first", fs1, 240);
    check("c_fs_period", fs2 - fs1, 240);
    check("c_fs_count", fs_cnt, 13);
    check("c_fs_wide", fs_wide, 0);
    check("c_vid_ticks_f1", c_vid_f1, 32);
    check("c_vid_ticks_f2", c_vid_f2, 32);
    check("c_vs_low_clk", c_vs_low, 60);
    check("c_vs_vs_y", c_vs_bad, 0);
    check("c_y_wrap_edge", c_ywrap_e, 240);

    // Run u_a to (300,1), then assert reset between edges.
    w = 0;
    while (!(a_px == 10'd300 && a_py == 10'd1) && w < 2000) begin
      step(1);
      w++;
    end
    check("reach_x300", int'(a_px), 300);
    check("pre_rst_video_on", int'(a_vid), 1);
    reset_n = 1'b0;
    #1;
    check_reset_a("async");
    check("async_c_pixel_x", int'(c_px), 0);
    step(3);
    check_reset_a("held");
    reset_n = 1'b1;
    step(1);
    check("re_e1_video_on", int'(a_vid), 1);
    check("re_e1_pixel_x", int'(a_px), 0);
    step(2);
    check("re_e3_p_tick", int'(a_pt), 1);
    step(1);
    check("re_e4_pixel_x", int'(a_px), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
